// File: rtl/mod10_counter.sv
// mod10_counter: 4-bit decade counter with parallel load and logical left shift.
// Latency: 1 cycle from sampled enable to new value on out; no in->out comb path.
// Backpressure: none; every enable is acted on at the next rising edge.
//
// Ports (positional order is fixed so older positional instances keep working):
//   clk    in   1      rising-edge clock
//   load   in   1      parallel-load enable
//   shift  in   1      shift-left enable
//   count  in   1      count-up enable
//   in     in   WIDTH  parallel load data
//   out    out  WIDTH  registered counter value
//   rst    in   1      synchronous reset, active-high
//   tc     out  1      terminal count / cascade carry (only with MOD10_COUNTER_TC_EN)
//
// Priority on each edge: rst > shift > load > count > hold.
// Optional feature macro: MOD10_COUNTER_TC_EN adds the combinational tc output.
// Power-up value before the first reset is undefined.

module mod10_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             load,
  input  logic             shift,
  input  logic             count,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  input  logic             rst
`ifdef MOD10_COUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  // Reject configurations that cannot hold the full count range or that
  // would leave the shifter without a bit to move.
  if (WIDTH < 2) begin : g_bad_width
    $error("mod10_counter: WIDTH must be at least 2");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod10_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // Largest in-range value; counting from here (or anything above) wraps to 0.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             at_max;

  // Values loaded or shifted past MAX_VAL are treated as "at or past the end"
  // so the next count returns them to 0 instead of walking up to 2**WIDTH-1.
  assign at_max = (out_q >= MAX_VAL);

  always_comb begin
    out_d = out_q;
    if (shift) begin
      // Logical shift: MSB dropped, zero fill, no modulus check.
      out_d = {out_q[WIDTH-2:0], 1'b0};
    end else if (load) begin
      // Loaded verbatim, even out-of-range data.
      out_d = in;
    end else if (count) begin
      if (at_max) begin
        out_d = '0;
      end else begin
        out_d = out_q + WIDTH'(1);
      end
    end
  end

  // rst lives here rather than in out_d so it overrides every enable path.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef MOD10_COUNTER_TC_EN
  // Carry into the next decade stage: asserted only when this edge will
  // actually wrap via counting, so a load or shift on the same cycle masks it.
  // Exact equality on purpose; out-of-range values do not produce a carry.
  assign tc = count & ~load & ~shift & (out_q == MAX_VAL);
`endif

endmodule

// File: tb/tb_mod10_counter.sv
// Directed bench for mod10_counter: reset, counting with wrap, load, shift
// priority, out-of-range recovery and reset priority. tc is checked only when
// MOD10_COUNTER_TC_EN is defined for the build.

module tb_mod10_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic       shift;
  logic       count;
  logic [3:0] in;
  logic [3:0] out;
`ifdef MOD10_COUNTER_TC_EN
  logic       tc;
`endif

  int checks = 0;
  int errors = 0;

  mod10_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk   (clk),
    .load  (load),
    .shift (shift),
    .count (count),
    .in    (in),
    .out   (out),
    .rst   (rst)
`ifdef MOD10_COUNTER_TC_EN
    ,
    .tc    (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; shift = 1'b0; count = 1'b0; in = 4'd0;
    #2;

    // 1. Reset for two cycles, then release and hold.
    rst = 1'b1;
    tick(); tick();
    check("reset", out, 4'd0);
    rst = 1'b0;
    tick();
    check("hold_after_reset", out, 4'd0);
    tick();
    check("hold_after_reset2", out, 4'd0);

    // 2. Count 12 cycles: 1..9, wrap to 0, then 1, 2.
    count = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("count_step%0d", i), out, 4'((i) % 10));
`ifdef MOD10_COUNTER_TC_EN
      check($sformatf("tc_step%0d", i), {3'b000, tc}, (i % 10 == 9) ? 4'd1 : 4'd0);
`endif
    end

    // No enables: value holds at 2.
    count = 1'b0;
    tick();
    check("idle_hold", out, 4'd2);

    // 3. Load 7 and keep loading.
    load = 1'b1; in = 4'd7;
    tick();
    check("load7", out, 4'd7);
    tick();
    check("load7_hold", out, 4'd7);

    // 4. Shift beats load: 14, 12, 8, 0, 0.
    shift = 1'b1;
    tick(); check("shift1", out, 4'd14);
    tick(); check("shift2", out, 4'd12);
    tick(); check("shift3", out, 4'd8);
    tick(); check("shift4", out, 4'd0);
    tick(); check("shift5", out, 4'd0);

    // 5. Out-of-range load of 12 recovers to 0 on the next count.
    shift = 1'b0; load = 1'b1; in = 4'd12;
    tick();
    check("load12", out, 4'd12);
    load = 1'b0; count = 1'b1;
`ifdef MOD10_COUNTER_TC_EN
    check("tc_out_of_range", {3'b000, tc}, 4'd0);
`endif
    tick();
    check("recover0", out, 4'd0);
    tick();
    check("recover1", out, 4'd1);

    // Load of 15 (all ones) also wraps to 0 on count.
    count = 1'b0; load = 1'b1; in = 4'd15;
    tick();
    check("load15", out, 4'd15);
    load = 1'b0; count = 1'b1;
    tick();
    check("recover15", out, 4'd0);

    // 6. Count 1..5, then rst with count and load asserted.
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("recount%0d", i), out, 4'(i));
    end
    rst = 1'b1; load = 1'b1; in = 4'd7;
    tick();
    check("rst_priority", out, 4'd0);
    rst = 1'b0; load = 1'b0;
    tick();
    check("resume1", out, 4'd1);
    tick();
    check("resume2", out, 4'd2);

`ifdef MOD10_COUNTER_TC_EN
    // tc is masked by load even when sitting at 9 with count asserted.
    count = 1'b0; load = 1'b1; in = 4'd9;
    tick();
    check("load9", out, 4'd9);
    count = 1'b1;
    check("tc_masked_by_load", {3'b000, tc}, 4'd0);
    load = 1'b0;
    check("tc_at9", {3'b000, tc}, 4'd1);
    tick();
    check("wrap_from_load9", out, 4'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
